// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, samples
// synchronised rows, and commits a debounced 6-bit key code (0 = no key).
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  output logic [3:0] Keyp_Col_O,
  input  logic [3:0] Keyp_Row_I,
  output logic [5:0] Key_Value,
  output logic       Key_Valid,
  output logic       Key_Strobe
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic [1:0]    col_next;
  logic [4:0]    acc;
  logic [4:0]    candidate;
  logic [SW-1:0] stable;
  logic [SW-1:0] stable_inc;

  logic          sample;
  logic          scan_end;
  logic [4:0]    hit;
  logic [4:0]    scan_code;

  assign sample     = (dwell == DWELL_LAST);
  assign scan_end   = sample && (col_idx == 2'd3);
  assign col_next   = col_idx + 2'd1;
  assign stable_inc = stable + SW'(1);

  // Lowest pressed row of the driven column; iterate high-to-low so row 0 wins.
  always_comb begin
    hit = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!row_sync[3 - r]) begin
        hit = 5'({col_idx, 2'(3 - r)}) + 5'd1;
      end
    end
  end

  // Earlier columns already hold the lowest code, so a non-zero acc wins.
  assign scan_code = (acc != '0) ? acc : hit;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= Keyp_Row_I;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      dwell      <= '0;
      col_idx    <= '0;
      Keyp_Col_O <= 4'b1110;
      acc        <= '0;
    end else if (sample) begin
      dwell      <= '0;
      col_idx    <= col_next;
      Keyp_Col_O <= ~(4'b0001 << col_next);
      acc        <= (col_idx == 2'd3) ? '0 : scan_code;
    end else begin
      dwell      <= dwell + DW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      candidate  <= '0;
      stable     <= '0;
      Key_Value  <= '0;
      Key_Valid  <= 1'b0;
      Key_Strobe <= 1'b0;
    end else begin
      Key_Strobe <= 1'b0;
      if (scan_end) begin
        if (scan_code != candidate) begin
          candidate <= scan_code;
          stable    <= SW'(1);
        end else if (stable < STABLE_MAX) begin
          stable <= stable_inc;
          if (stable_inc == STABLE_MAX) begin
            Key_Value  <= {1'b0, candidate};
            Key_Valid  <= (candidate != '0);
            Key_Strobe <= (candidate != '0) && ({1'b0, candidate} != Key_Value);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a physical keypad model and a
// scan-history reference model of the debounce behaviour.
module tb_keypad_scanner;

  localparam int SD = 8;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_o;
  logic [3:0] row_i;
  logic [5:0] key_value;
  logic       key_valid;
  logic       key_strobe;
  logic [15:0] pressed = '0;

  int n_cmp = 0;
  int n_err = 0;

  int hist[$];
  int committed = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .Clock      (clk),
    .Reset      (rst),
    .Keyp_Col_O (col_o),
    .Keyp_Row_I (row_i),
    .Key_Value  (key_value),
    .Key_Valid  (key_valid),
    .Key_Strobe (key_strobe)
  );

  always #5 clk = ~clk;

  // Idealised keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_i = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4 + r] && !col_o[c]) row_i[r] = 1'b0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    hist.delete();
    committed = 0;
  endfunction

  // Key index = col*4+row, code = index+1; lowest code wins. A value is
  // committed once the last DB scan results agree.
  function automatic void model_step(input logic [15:0] m, output int exp_val, output bit exp_strobe);
    int res = 0;
    bit same = 1'b1;
    for (int i = 15; i >= 0; i--) if (m[i]) res = i + 1;
    hist.push_back(res);
    exp_strobe = 1'b0;
    if (hist.size() >= DB) begin
      for (int k = 1; k <= DB; k++) if (hist[hist.size()-k] != res) same = 1'b0;
      if (same && res != committed) begin
        exp_strobe = (res != 0);
        committed = res;
      end
    end
    exp_val = committed;
  endfunction

  // One full scan from a scan boundary: applies mask, gathers observations.
  task automatic run_scan(input logic [15:0] m, output int strobes, output logic last, output int bad_cols);
    pressed = m;
    strobes = 0;
    bad_cols = 0;
    for (int c = 0; c < 4*SD; c++) begin
      @(posedge clk); #1;
      if (key_strobe === 1'b1) strobes++;
      if (!(col_o inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) bad_cols++;
    end
    last = key_strobe;
  endtask

  task automatic test_reset();
    pressed = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (col_o !== 4'b1110) begin n_err++; $display("FAIL reset col: got %b want 1110", col_o); end
    n_cmp++; if (key_value !== 6'd0) begin n_err++; $display("FAIL reset value: got %0d want 0", key_value); end
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset valid: got %b want 0", key_valid); end
    n_cmp++; if (key_strobe !== 1'b0) begin n_err++; $display("FAIL reset strobe: got %b want 0", key_strobe); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_columns();
    int ev;
    bit es;
    logic [3:0] want;
    pressed = '0;
    for (int k = 1; k <= 4*SD; k++) begin
      @(posedge clk); #1;
      want = ~(4'b0001 << ((k / SD) % 4));
      n_cmp++; if (col_o !== want) begin n_err++; $display("FAIL column seq cycle %0d: got %b want %b", k, col_o, want); end
    end
    model_step('0, ev, es);
    n_cmp++; if (key_value !== 6'(ev)) begin n_err++; $display("FAIL column idle value: got %0d want %0d", key_value, ev); end
  endtask

  task automatic test_press_release();
    logic [15:0] tbl [9] = '{16'h0020, 16'h0020, 16'h0020, 16'h0020, 16'h0020,
                             16'h0000, 16'h0000, 16'h0000, 16'h0000};
    int ns, bad, ev;
    logic last;
    bit es;
    foreach (tbl[i]) begin
      run_scan(tbl[i], ns, last, bad);
      model_step(tbl[i], ev, es);
      n_cmp++; if (key_value !== 6'(ev)) begin n_err++; $display("FAIL press value scan %0d: got %0d want %0d", i, key_value, ev); end
      n_cmp++; if (key_valid !== (ev != 0)) begin n_err++; $display("FAIL press valid scan %0d: got %b want %b", i, key_valid, ev != 0); end
      n_cmp++; if (ns !== int'(es) || last !== es) begin n_err++; $display("FAIL press strobe scan %0d: got %0d pulses last %b want %0d", i, ns, last, es); end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL press column onehot scan %0d: got %0d bad cycles want 0", i, bad); end
    end
  endtask

  task automatic test_bounce();
    logic [15:0] tbl [9] = '{16'h0020, 16'h0000, 16'h0020, 16'h0000,
                             16'h0020, 16'h0020, 16'h0020, 16'h0020, 16'h0000};
    int ns, bad, ev, total = 0, want_total = 0;
    logic last;
    bit es;
    foreach (tbl[i]) begin
      run_scan(tbl[i], ns, last, bad);
      model_step(tbl[i], ev, es);
      total += ns;
      want_total += int'(es);
      n_cmp++; if (key_value !== 6'(ev)) begin n_err++; $display("FAIL bounce value scan %0d: got %0d want %0d", i, key_value, ev); end
      n_cmp++; if (ns !== int'(es) || last !== es) begin n_err++; $display("FAIL bounce strobe scan %0d: got %0d pulses last %b want %0d", i, ns, last, es); end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL bounce column onehot scan %0d: got %0d bad cycles want 0", i, bad); end
    end
    n_cmp++; if (total !== 1 || want_total !== 1) begin n_err++; $display("FAIL bounce strobe total: got %0d model %0d want 1", total, want_total); end
  endtask

  task automatic test_two_keys();
    logic [15:0] tbl [11] = '{16'h8001, 16'h8001, 16'h8001, 16'h8001,
                              16'h8000, 16'h8000, 16'h8000, 16'h8000,
                              16'h0000, 16'h0000, 16'h0000};
    int ns, bad, ev;
    logic last;
    bit es;
    foreach (tbl[i]) begin
      run_scan(tbl[i], ns, last, bad);
      model_step(tbl[i], ev, es);
      n_cmp++; if (key_value !== 6'(ev)) begin n_err++; $display("FAIL twokey value scan %0d: got %0d want %0d", i, key_value, ev); end
      n_cmp++; if (key_valid !== (ev != 0)) begin n_err++; $display("FAIL twokey valid scan %0d: got %b want %b", i, key_valid, ev != 0); end
      n_cmp++; if (ns !== int'(es) || last !== es) begin n_err++; $display("FAIL twokey strobe scan %0d: got %0d pulses last %b want %0d", i, ns, last, es); end
    end
  endtask

  task automatic test_reset_mid();
    int ns, bad, ev;
    logic last;
    bit es;
    for (int i = 0; i < 2; i++) begin
      run_scan(16'h0400, ns, last, bad);
      model_step(16'h0400, ev, es);
      n_cmp++; if (key_value !== 6'(ev)) begin n_err++; $display("FAIL midreset pre value scan %0d: got %0d want %0d", i, key_value, ev); end
    end
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (col_o !== 4'b1110) begin n_err++; $display("FAIL midreset col cycle %0d: got %b want 1110", c, col_o); end
      n_cmp++; if (key_value !== 6'd0 || key_valid !== 1'b0) begin n_err++; $display("FAIL midreset outputs cycle %0d: got %0d/%b want 0/0", c, key_value, key_valid); end
      n_cmp++; if (key_strobe !== 1'b0) begin n_err++; $display("FAIL midreset strobe cycle %0d: got %b want 0", c, key_strobe); end
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      run_scan(16'h0400, ns, last, bad);
      model_step(16'h0400, ev, es);
      n_cmp++; if (key_value !== 6'(ev)) begin n_err++; $display("FAIL midreset post value scan %0d: got %0d want %0d", i, key_value, ev); end
      n_cmp++; if (ns !== int'(es) || last !== es) begin n_err++; $display("FAIL midreset post strobe scan %0d: got %0d pulses last %b want %0d", i, ns, last, es); end
    end
  endtask

  task automatic test_random();
    logic [15:0] m = '0;
    int ns, bad, ev;
    logic last;
    bit es;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        m = '0;
        repeat ($urandom_range(0, 2)) m[$urandom_range(0, 15)] = 1'b1;
      end
      run_scan(m, ns, last, bad);
      model_step(m, ev, es);
      n_cmp++; if (key_value !== 6'(ev)) begin n_err++; $display("FAIL random value scan %0d mask %h: got %0d want %0d", i, m, key_value, ev); end
      n_cmp++; if (key_valid !== (ev != 0)) begin n_err++; $display("FAIL random valid scan %0d: got %b want %b", i, key_valid, ev != 0); end
      n_cmp++; if (ns !== int'(es) || last !== es) begin n_err++; $display("FAIL random strobe scan %0d: got %0d pulses last %b want %0d", i, ns, last, es); end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL random column onehot scan %0d: got %0d bad cycles want 0", i, bad); end
    end
  endtask

  initial begin
    test_reset();
    test_columns();
    test_press_release();
    test_bounce();
    test_two_keys();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
